// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
//
// Purpose : AHB-Lite bus bundle between one master (or interconnect) and the
//           SRAM slave. Signal names follow the AHB naming used on the bus.
//
// Signals :
//   HSEL       slave select
//   HADDR      byte address                       [ADDR_WIDTH-1:0]
//   HTRANS     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 byte, 1 halfword, 2 word
//   HPROT      protection control (carried, not interpreted)
//   HWDATA     write data, valid in the data phase [DATA_WIDTH-1:0]
//   HREADY     bus-level ready (from the interconnect)
//   HRDATA     read data                          [DATA_WIDTH-1:0]
//   HREADYOUT  slave ready
//   HRESP      0 = OKAY, 1 = ERROR
//
// Handshake : an address phase is taken on a rising edge with HSEL=1,
//   HREADY=1 and HTRANS[1]=1. The data phase that follows ends on the first
//   rising edge where HREADYOUT=1; until then the master must hold HWDATA.
//   HRDATA and HRESP are meaningful in the cycle where HREADYOUT=1 (HRESP is
//   also raised in the HREADYOUT=0 cycle that opens an ERROR response).
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// Purpose : AHB-Lite slave in front of a MEM_DEPTH x 32-bit SRAM with byte
//           lane writes, read-after-write forwarding, optional wait states and
//           the two-cycle AHB ERROR response for misaligned or out-of-range
//           accesses.
//
// Ports   :
//   HCLK       clock
//   HRESETn    synchronous active-low reset
//   bus        ahb_sram_slave_if.slave (AHB address/data/response signals)
//   dbg_state  current FSM state (S_IDLE/S_WAIT/S_ERR1/S_ERR2)
//
// Parameters :
//   ADDR_WIDTH  address width (default 16)
//   DATA_WIDTH  data width, 32 only
//   MEM_DEPTH   number of 32-bit words (default 1024)
//   WAIT_STATES HREADYOUT-low cycles per OKAY transfer, 0..7 (default 0)
//
// Handshake : a transfer is taken when HSEL & HREADY & HTRANS[1] on a rising
//   edge; its data phase completes on the first rising edge with HREADYOUT=1.
//   Write data is committed to memory on that completing edge; read data is
//   loaded into HRDATA on the address edge and is valid while HREADYOUT=1.
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_sram_slave_if.slave    bus,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  // FSM and wait counter
  logic [1:0]       state;
  logic [2:0]       wait_cnt;

  // Data-phase record of the transfer currently in its data phase.
  // Only OKAY transfers set dp_valid; error transfers never touch memory.
  logic             dp_valid;
  logic             dp_write;
  logic [3:0]       dp_be;
  logic [IDX_W-1:0] dp_idx;

  logic [31:0]      mem [MEM_DEPTH];
  logic [31:0]      hrdata_q;

  // Address-phase decode
  logic             hready_out;
  logic             accept;
  logic             addr_err;
  logic [31:0]      word_addr;
  logic [3:0]       a_be;
  logic [IDX_W-1:0] a_idx;
  logic             commit;
  logic [31:0]      rd_merged;
  logic             unused_ok;

  // The slave is ready in IDLE (including the last cycle of a wait-stated
  // transfer) and in ERR2; WAIT and ERR1 stall the bus.
  assign hready_out = (state == S_IDLE) || (state == S_ERR2);

  // HREADY is the bus view of our own HREADYOUT while we own a data phase,
  // so gating with hready_out only guards against an ill-behaved master.
  assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hready_out;

  assign word_addr = 32'(bus.HADDR[ADDR_WIDTH-1:2]);
  assign a_idx     = bus.HADDR[IDX_W+1:2];

  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > 3'd2)                                  addr_err = 1'b1;
    if ((bus.HSIZE == 3'd1) && bus.HADDR[0])               addr_err = 1'b1;
    if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))  addr_err = 1'b1;
    if (word_addr >= 32'(MEM_DEPTH))                       addr_err = 1'b1;
  end

  // Little-endian byte lanes for the access size.
  always_comb begin
    a_be = 4'b0000;
    case (bus.HSIZE[1:0])
      2'd0:    a_be = 4'b0001 << bus.HADDR[1:0];
      2'd1:    a_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: a_be = 4'b1111;
    endcase
  end

  // A write lands on the edge that closes its data phase. Reset on that edge
  // drops it.
  assign commit = hready_out && dp_valid && dp_write && HRESETn;

  // Read data for a new address phase; if a write to the same word is being
  // committed on this same edge, its lanes take priority over the stale word.
  always_comb begin
    rd_merged = mem[a_idx];
    if (commit && (dp_idx == a_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) rd_merged[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) mem[dp_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_be    <= 4'b0000;
      dp_idx   <= '0;
      hrdata_q <= 32'h0;
    end else if (hready_out) begin
      // IDLE or ERR2: the current data phase (if any) completes on this edge
      // and a new address phase may be taken.
      dp_valid <= accept && !addr_err;
      dp_write <= bus.HWRITE;
      dp_be    <= a_be;
      dp_idx   <= a_idx;
      if (accept) begin
        if (addr_err) begin
          state    <= S_ERR1;
          hrdata_q <= 32'h0;
        end else begin
          if (!bus.HWRITE) hrdata_q <= rd_merged;
          if (WS != 3'd0) begin
            state    <= S_WAIT;
            wait_cnt <= WS;
          end else begin
            state    <= S_IDLE;
          end
        end
      end else begin
        state <= S_IDLE;
      end
    end else if (state == S_WAIT) begin
      // WAIT lasts exactly WS cycles; the following IDLE cycle carries
      // HREADYOUT=1 and closes the data phase.
      wait_cnt <= wait_cnt - 3'd1;
      if (wait_cnt == 3'd1) state <= S_IDLE;
    end else begin
      state <= S_ERR2;
    end
  end

  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign bus.HRDATA    = hrdata_q;
  assign dbg_state     = state;

  // HTRANS[0] (NONSEQ vs SEQ) and HPROT do not change slave behaviour.
  assign unused_ok = ^{bus.HTRANS[0], bus.HPROT};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Two slaves share the clock: dut0 (WAIT_STATES=0) and dut3 (WAIT_STATES=3).
// dut0 is exercised by a directed table, randomized traffic against a
// byte-array reference model, and reset-abort sequences; dut3 by hand-written
// wait-state and reset-in-WAIT sequences. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int AW = 16;
  localparam int DW = 32;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst0_n;
  logic       rst3_n;
  logic [1:0] dbg0;
  logic [1:0] dbg3;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a0 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a3 ();

  // Single-slave bus: HREADY is the slave's own HREADYOUT.
  assign a0.HREADY = a0.HREADYOUT;
  assign a3.HREADY = a3.HREADYOUT;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024),
                   .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst0_n), .bus(a0), .dbg_state(dbg0));

  ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024),
                   .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst3_n), .bus(a3), .dbg_state(dbg3));

  // scoreboard state
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        write;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  // Per-cycle expectation for dut0: {hreadyout, hresp, hrdata}
  logic [33:0] exp_q[$];

  // Reference model: byte-addressed memory, the write waiting for its data
  // phase to close, and the value HRDATA should currently be holding.
  logic [7:0]  ref_mem [4096];
  bit          prev_valid;
  logic [2:0]  prev_size;
  logic [15:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [2:0] size, input logic [15:0] addr);
    int a;
    a = int'(addr);
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && (a % 2) != 0) return 1'b1;
    if (size == 3'd2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= 1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    logic [31:0] w;
    int b;
    b = (int'(addr) / 4) * 4;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[b + i];
    return w;
  endfunction

  task automatic commit_prev();
    int a;
    int n;
    if (prev_valid) begin
      a = int'(prev_addr);
      n = 1 << prev_size;
      for (int i = 0; i < n; i++) ref_mem[a + i] = prev_wdata[8*((a + i) % 4) +: 8];
      prev_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_valid = 1'b0;
    last_rd    = 32'h0;
  endtask

  task automatic check_cycle(output logic rdy);
    logic [33:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 1'b0, last_rd};
    check("hreadyout", {31'b0, a0.HREADYOUT}, {31'b0, e[33]});
    check("hresp",     {31'b0, a0.HRESP},     {31'b0, e[32]});
    check("hrdata",    a0.HRDATA,             e[31:0]);
    rdy = a0.HREADYOUT;
  endtask

  // Drive one address phase on dut0 (called on a falling edge where the bus
  // is ready), then follow its data phase until HREADYOUT=1.
  task automatic do_xfer(input vec_t v, input bit use_tbl);
    logic err;
    logic r;
    int   n;
    commit_prev();
    a0.HSEL   = 1'b1;
    a0.HTRANS = v.trans;
    a0.HWRITE = v.write;
    a0.HSIZE  = v.size;
    a0.HADDR  = v.addr;
    a0.HPROT  = 4'($urandom_range(0, 15));
    err = use_tbl ? v.exp_err : model_err(v.size, v.addr);
    if (err) begin
      last_rd = 32'h0;
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      exp_q.push_back({1'b1, 1'b1, 32'h0});
    end else begin
      if (!v.write) last_rd = use_tbl ? v.exp_rd : model_read(v.addr);
      exp_q.push_back({1'b1, 1'b0, last_rd});
      if (v.write) begin
        prev_valid = 1'b1;
        prev_size  = v.size;
        prev_addr  = v.addr;
        prev_wdata = v.wdata;
      end
    end
    n = 0;
    r = 1'b0;
    while (!r && n < 16) begin
      @(negedge clk);
      check_cycle(r);
      a0.HTRANS = T_IDLE;
      a0.HWDATA = v.wdata;
      n++;
    end
    if (!r) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: hreadyout stuck at %b, expected 1 within 16 cycles", a0.HREADYOUT);
    end
  endtask

  task automatic idle_cycle(input logic sel, input logic [1:0] trans);
    logic r;
    commit_prev();
    a0.HSEL   = sel;
    a0.HTRANS = trans;
    a0.HWRITE = 1'($urandom_range(0, 1));
    a0.HADDR  = 16'($urandom_range(0, 255));
    a0.HSIZE  = 3'd2;
    @(negedge clk);
    check_cycle(r);
    a0.HTRANS = T_IDLE;
  endtask

  // dut3: one word transfer with exactly three stall cycles.
  task automatic d3_xfer(input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
    a3.HSEL   = 1'b1;
    a3.HTRANS = T_NSEQ;
    a3.HWRITE = wr;
    a3.HSIZE  = 3'd2;
    a3.HADDR  = addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ws3_wait_ready", {31'b0, a3.HREADYOUT}, 32'd0);
      check("ws3_wait_resp",  {31'b0, a3.HRESP},     32'd0);
      a3.HTRANS = T_IDLE;
      a3.HWDATA = wdata;
    end
    @(negedge clk);
    check("ws3_done_ready", {31'b0, a3.HREADYOUT}, 32'd1);
    check("ws3_done_resp",  {31'b0, a3.HRESP},     32'd0);
    check("ws3_hrdata",     a3.HRDATA,             exp_rd);
  endtask

  vec_t tbl [18];
  vec_t v;

  initial begin
    tbl[0]  = '{1'b1, T_NSEQ, 3'd2, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, T_SEQ,  3'd2, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, T_NSEQ, 3'd2, 16'h0020, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, T_NSEQ, 3'd0, 16'h0021, 32'h0000AA00, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, T_SEQ,  3'd1, 16'h0022, 32'hBBCC0000, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, T_NSEQ, 3'd2, 16'h0020, 32'h0,        1'b0, 32'hBBCCAA44};
    tbl[6]  = '{1'b1, T_NSEQ, 3'd2, 16'h0040, 32'h12345678, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, T_NSEQ, 3'd2, 16'h0040, 32'h0,        1'b0, 32'h12345678};
    tbl[8]  = '{1'b1, T_NSEQ, 3'd2, 16'h0000, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, T_NSEQ, 3'd2, 16'h0002, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[10] = '{1'b0, T_NSEQ, 3'd2, 16'h0002, 32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b0, T_NSEQ, 3'd2, 16'h0000, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[12] = '{1'b0, T_NSEQ, 3'd2, 16'h1000, 32'h0,        1'b1, 32'h0};
    tbl[13] = '{1'b1, T_NSEQ, 3'd0, 16'h1003, 32'h55000000, 1'b1, 32'h0};
    tbl[14] = '{1'b0, T_NSEQ, 3'd1, 16'h0031, 32'h0,        1'b1, 32'h0};
    tbl[15] = '{1'b0, T_NSEQ, 3'd3, 16'h0030, 32'h0,        1'b1, 32'h0};
    tbl[16] = '{1'b0, T_NSEQ, 3'd0, 16'h0023, 32'h0,        1'b0, 32'hBBCCAA44};
    tbl[17] = '{1'b0, T_SEQ,  3'd1, 16'h0022, 32'h0,        1'b0, 32'hBBCCAA44};

    // reset
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    a0.HSEL = 1'b0; a0.HTRANS = T_IDLE; a0.HWRITE = 1'b0; a0.HSIZE = 3'd0;
    a0.HADDR = 16'h0; a0.HPROT = 4'h0; a0.HWDATA = 32'h0;
    a3.HSEL = 1'b0; a3.HTRANS = T_IDLE; a3.HWRITE = 1'b0; a3.HSIZE = 3'd0;
    a3.HADDR = 16'h0; a3.HPROT = 4'h0; a3.HWDATA = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst0_ready",  {31'b0, a0.HREADYOUT}, 32'd1);
    check("rst0_resp",   {31'b0, a0.HRESP},     32'd0);
    check("rst0_hrdata", a0.HRDATA,             32'h0);
    check("rst0_state",  {30'b0, dbg0},         32'd0);
    check("rst3_ready",  {31'b0, a3.HREADYOUT}, 32'd1);
    check("rst3_resp",   {31'b0, a3.HRESP},     32'd0);
    check("rst3_hrdata", a3.HRDATA,             32'h0);
    check("rst3_state",  {30'b0, dbg3},         32'd0);
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // Fill the low window so every later read has a defined model value.
    // The first transfer is driven for the first edge with reset released.
    for (int w = 0; w < 64; w++) begin
      v = '{1'b1, T_NSEQ, 3'd2, 16'(w * 4), $urandom(), 1'b0, 32'h0};
      do_xfer(v, 1'b0);
    end

    // directed table
    for (int i = 0; i < 18; i++) do_xfer(tbl[i], 1'b1);
    idle_cycle(1'b1, T_IDLE);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       idle_cycle(1'b1, T_IDLE);
          1:       idle_cycle(1'b1, T_BUSY);
          default: idle_cycle(1'b0, T_NSEQ);
        endcase
      end else begin
        v.write   = 1'($urandom_range(0, 1));
        v.trans   = ($urandom_range(0, 1) == 0) ? T_NSEQ : T_SEQ;
        v.size    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2));
        v.addr    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h1000, 16'hFFFF))
                                                : 16'($urandom_range(0, 255));
        v.wdata   = $urandom();
        v.exp_err = 1'b0;
        v.exp_rd  = 32'h0;
        do_xfer(v, 1'b0);
      end
    end
    idle_cycle(1'b1, T_IDLE);

    // dut0: reset during ERR1
    a0.HSEL = 1'b1; a0.HTRANS = T_NSEQ; a0.HWRITE = 1'b0; a0.HSIZE = 3'd2;
    a0.HADDR = 16'h0002;
    @(negedge clk);
    check("err1_ready", {31'b0, a0.HREADYOUT}, 32'd0);
    check("err1_resp",  {31'b0, a0.HRESP},     32'd1);
    check("err1_state", {30'b0, dbg0},         32'd2);
    rst0_n = 1'b0;
    a0.HTRANS = T_IDLE;
    @(negedge clk);
    check("err1_rst_ready",  {31'b0, a0.HREADYOUT}, 32'd1);
    check("err1_rst_resp",   {31'b0, a0.HRESP},     32'd0);
    check("err1_rst_hrdata", a0.HRDATA,             32'h0);
    check("err1_rst_state",  {30'b0, dbg0},         32'd0);
    rst0_n = 1'b1;
    model_reset();

    // dut0: reset during a write data phase drops the write
    a0.HSEL = 1'b1; a0.HTRANS = T_NSEQ; a0.HWRITE = 1'b1; a0.HSIZE = 3'd2;
    a0.HADDR = 16'h0044;
    @(negedge clk);
    check("wr_dp_ready", {31'b0, a0.HREADYOUT}, 32'd1);
    a0.HWDATA = 32'h99999999;
    a0.HTRANS = T_IDLE;
    rst0_n = 1'b0;
    @(negedge clk);
    check("wr_rst_ready",  {31'b0, a0.HREADYOUT}, 32'd1);
    check("wr_rst_resp",   {31'b0, a0.HRESP},     32'd0);
    check("wr_rst_hrdata", a0.HRDATA,             32'h0);
    rst0_n = 1'b1;
    model_reset();
    v = '{1'b0, T_NSEQ, 3'd2, 16'h0044, 32'h0, 1'b0, 32'h0};
    do_xfer(v, 1'b0);
    idle_cycle(1'b1, T_IDLE);

    // dut3: wait states, forwarding across a stalled write, reset in WAIT
    d3_xfer(1'b1, 16'h0010, 32'hA5A55A5A, 32'h0);
    d3_xfer(1'b0, 16'h0010, 32'h0,        32'hA5A55A5A);
    d3_xfer(1'b1, 16'h0030, 32'h0BADF00D, 32'hA5A55A5A);
    a3.HSEL = 1'b1; a3.HTRANS = T_NSEQ; a3.HWRITE = 1'b1; a3.HSIZE = 3'd2;
    a3.HADDR = 16'h0030;
    @(negedge clk);
    check("w3rst_wait1", {31'b0, a3.HREADYOUT}, 32'd0);
    a3.HTRANS = T_IDLE;
    a3.HWDATA = 32'hFFFFFFFF;
    @(negedge clk);
    check("w3rst_wait2", {31'b0, a3.HREADYOUT}, 32'd0);
    check("w3rst_state", {30'b0, dbg3},         32'd1);
    rst3_n = 1'b0;
    @(negedge clk);
    check("w3rst_ready",  {31'b0, a3.HREADYOUT}, 32'd1);
    check("w3rst_resp",   {31'b0, a3.HRESP},     32'd0);
    check("w3rst_hrdata", a3.HRDATA,             32'h0);
    check("w3rst_state0", {30'b0, dbg3},         32'd0);
    rst3_n = 1'b1;
    d3_xfer(1'b0, 16'h0030, 32'h0, 32'h0BADF00D);
    @(negedge clk);
    check("ws3_idle_ready", {31'b0, a3.HREADYOUT}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
